// File: rtl/csea_pkg.sv
// Shared types, default geometry and configuration check for the
// pipelined carry-select adder/subtractor.
package csea_pkg;

  localparam int CSEA_WIDTH  = 32;
  localparam int CSEA_BLK    = 4;
  localparam int CSEA_STAGES = 2;

  typedef struct packed {
    logic [CSEA_WIDTH-1:0] sum;
    logic                  cout;
    logic                  ovf;
  } csea_res_t;

  // Width must split into whole blocks, and blocks into equal stage groups.
  function automatic bit csea_cfg_ok(input int width, input int blk, input int stages);
    return (blk >= 1) && (stages >= 1) && (width % blk == 0) &&
           ((width / blk) % stages == 0);
  endfunction

endpackage

// File: rtl/csea_blk.sv
// One combinational carry-select block: two precomputed ripple sums muxed
// by the incoming carry, or a plain ripple block when RIPPLE is set.
module csea_blk
  import csea_pkg::*;
#(
  parameter int BLK    = 4,
  parameter bit RIPPLE = 1'b0
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           c_in,
  output logic [BLK-1:0] s,
  output logic           c_out,
  output logic           c_msb_in
);

  // Packed as {carry into top bit, carry out, sum}.
  typedef logic [BLK+1:0] rca_t;

  function automatic rca_t rca(input logic [BLK-1:0] x, input logic [BLK-1:0] y,
                               input logic c);
    logic [BLK:0]   cy;
    logic [BLK-1:0] r;
    cy[0] = c;
    for (int i = 0; i < BLK; i++) begin
      r[i]    = x[i] ^ y[i] ^ cy[i];
      cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
    end
    return {cy[BLK-1], cy[BLK], r};
  endfunction

  if (RIPPLE) begin : g_ripple
    assign {c_msb_in, c_out, s} = rca(a, b, c_in);
  end else begin : g_select
    rca_t r0, r1;
    assign r0 = rca(a, b, 1'b0);
    assign r1 = rca(a, b, 1'b1);
    assign {c_msb_in, c_out, s} = c_in ? r1 : r0;
  end

endmodule

// File: rtl/csea_pipe.sv
// Pipelined carry-select adder/subtractor: stage g resolves block group g,
// with a global stall driven by the output handshake.
module csea_pipe
  import csea_pkg::*;
#(
  parameter int WIDTH  = CSEA_WIDTH,
  parameter int BLK    = CSEA_BLK,
  parameter int STAGES = CSEA_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLK;
  localparam int GB   = NBLK / STAGES;
  localparam int GWB  = GB * BLK;

  if (!csea_cfg_ok(WIDTH, BLK, STAGES)) begin : g_bad_cfg
    $error("csea_pipe: illegal WIDTH/BLK/STAGES combination");
  end

  logic             advance;
  logic             c0;
  logic             cm_top;
  logic [WIDTH-1:0] b_eff;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  for (genvar g = 0; g < STAGES; g++) begin : st
    // Operand bits still to be added (groups g and above) and sums so far.
    localparam int SW = WIDTH - g * GWB;
    logic [SW-1:0]          sa, sb;
    logic                   sc, sv;
    logic [GWB-1:0]         gs;
    logic [GB:0]            cc;
    logic [(g+1)*GWB-1:0]   sn;

    if (g == 0) begin : g_src
      assign sa = a;
      assign sb = b_eff;
      assign sc = c0;
      assign sv = in_valid;
      assign sn = gs;
    end else begin : g_src
      assign sa = st[g-1].g_fwd.a_p;
      assign sb = st[g-1].g_fwd.b_p;
      assign sc = st[g-1].g_fwd.c_p;
      assign sv = st[g-1].g_fwd.vld_p;
      assign sn = {gs, st[g-1].g_fwd.s_p};
    end

    assign cc[0] = sc;

    for (genvar j = 0; j < GB; j++) begin : bk
      if (g == STAGES - 1 && j == GB - 1) begin : g_top
        csea_blk #(.BLK(BLK), .RIPPLE(g == 0 && j == 0)) u_blk (
          .a(sa[j*BLK +: BLK]), .b(sb[j*BLK +: BLK]), .c_in(cc[j]),
          .s(gs[j*BLK +: BLK]), .c_out(cc[j+1]), .c_msb_in(cm_top)
        );
      end else begin : g_mid
        logic cm_unused;
        csea_blk #(.BLK(BLK), .RIPPLE(g == 0 && j == 0)) u_blk (
          .a(sa[j*BLK +: BLK]), .b(sb[j*BLK +: BLK]), .c_in(cc[j]),
          .s(gs[j*BLK +: BLK]), .c_out(cc[j+1]), .c_msb_in(cm_unused)
        );
      end
    end

    if (g < STAGES - 1) begin : g_fwd
      // ---- stage g -> g+1 boundary: group carry, finished sums, pending operands
      logic [SW-GWB-1:0]    a_p, b_p;
      logic [(g+1)*GWB-1:0] s_p;
      logic                 c_p;
      logic                 vld_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_p <= 1'b0;
        else if (advance) vld_p <= sv;
      end

      always_ff @(posedge clk) begin
        if (advance && sv) begin
          a_p <= sa[SW-1:GWB];
          b_p <= sb[SW-1:GWB];
          s_p <= sn;
          c_p <= cc[GB];
        end
      end
    end else begin : g_out
      // ---- final boundary: result registers, held while stalled
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (advance) begin
          out_valid <= sv;
          if (sv) begin
            sum  <= sn;
            cout <= cc[GB];
            ovf  <= cc[GB] ^ cm_top;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_csea_pipe.sv
// Directed and scoreboarded checks of csea_pipe at the default geometry plus
// three alternate geometries driven with carry-boundary operands.
module tb_csea_pipe;
  import csea_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic        out_valid, out_ready = 1'b1, cout, ovf;
  logic [31:0] a = '0, b = '0, sum;

  int checks = 0, errors = 0;

  csea_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Alternate geometries share one operand bus and never stall.
  logic        sw_valid = 1'b0, sw_cin = 1'b0, sw_sub = 1'b0;
  logic [63:0] sw_a = '0, sw_b = '0;
  logic        r16, r32, r64, v16, v32, v64, c16, c32, c64, o16, o32, o64;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [63:0] s64;

  csea_pipe #(.WIDTH(16), .BLK(4), .STAGES(1)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r16),
    .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v16),
    .out_ready(1'b1), .sum(s16), .cout(c16), .ovf(o16)
  );
  csea_pipe #(.WIDTH(32), .BLK(8), .STAGES(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r32),
    .a(sw_a[31:0]), .b(sw_b[31:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v32),
    .out_ready(1'b1), .sum(s32), .cout(c32), .ovf(o32)
  );
  csea_pipe #(.WIDTH(64), .BLK(4), .STAGES(4)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(v64),
    .out_ready(1'b1), .sum(s64), .cout(c64), .ovf(o64)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: plain integer add in 65 bits, carry into MSB recovered from bit parity.
  function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic s);
    logic [63:0] m, yy, xs, rs;
    logic [64:0] full;
    logic        co, cm;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xs   = x & m;
    yy   = (s ? ~y : y) & m;
    full = {1'b0, xs} + {1'b0, yy} + {64'd0, s | ci};
    rs   = full[63:0] & m;
    co   = full[w];
    cm   = rs[w-1] ^ xs[w-1] ^ yy[w-1];
    return {cm ^ co, co, rs};
  endfunction

  function automatic logic [33:0] exp32(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    logic [65:0] r;
    r = model(32, {32'd0, x}, {32'd0, y}, ci, s);
    return {r[65:64], r[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor for streaming phases.
  logic        mon_en = 1'b0, hold_v = 1'b0;
  logic [33:0] held;
  logic [33:0] exp_q[$];
  int          rcvd = 0, cyc_n = 0, first_t = 0, last_t = 0;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (hold_v && out_valid) chk("hold_stable", {32'd0, ovf, cout, sum}, {32'd0, held});
      hold_v = out_valid && !out_ready;
      held   = {ovf, cout, sum};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual=%0h required=none", {ovf, cout, sum});
        end else begin
          chk($sformatf("stream_beat%0d", rcvd), {32'd0, ovf, cout, sum}, {32'd0, exp_q.pop_front()});
        end
        if (rcvd == 0) first_t = cyc_n;
        last_t = cyc_n;
        rcvd++;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int        lat;
    csea_res_t got;
    out_ready = 1'b1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    got.sum = sum; got.cout = cout; got.ovf = ovf;
    chk({nm, "_lat"},  66'(lat), 66'd2);
    chk({nm, "_sum"},  {34'd0, got.sum}, {34'd0, v.sum});
    chk({nm, "_cout"}, {65'd0, got.cout}, {65'd0, v.cout});
    chk({nm, "_ovf"},  {65'd0, got.ovf}, {65'd0, v.ovf});
    step();
  endtask

  task automatic stream(input int n, input int st, input int sl, input string nm);
    logic [31:0] av[32], bv[32];
    logic        cv[32], sv[32];
    int          sent, cyc, r0;
    sent = 0; cyc = 0; r0 = rcvd;
    for (int i = 0; i < n; i++) begin
      av[i] = $urandom; bv[i] = $urandom;
      cv[i] = 1'($urandom_range(0, 1)); sv[i] = 1'($urandom_range(0, 1));
    end
    while (sent < n && cyc < 500) begin
      out_ready = !(cyc >= st && cyc < st + sl);
      a = av[sent]; b = bv[sent]; cin = cv[sent]; sub = sv[sent]; in_valid = 1'b1;
      #1;
      if (cyc == st + sl - 1) chk({nm, "_stall_in_ready"}, {65'd0, in_ready}, 66'd0);
      if (in_ready) begin
        exp_q.push_back(exp32(av[sent], bv[sent], cv[sent], sv[sent]));
        sent++;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
    step();
    chk({nm, "_delivered"}, 66'(rcvd - r0), 66'(n));
    chk({nm, "_pending"}, 66'(exp_q.size()), 66'd0);
  endtask

  logic [65:0] cap16, cap32, cap64;
  int          got16 = 0, got32 = 0, got64 = 0;

  always @(negedge clk) begin
    if (v16) begin cap16 = {o16, c16, 48'd0, s16}; got16++; end
    if (v32) begin cap32 = {o32, c32, 32'd0, s32}; got32++; end
    if (v64) begin cap64 = {o64, c64, s64};        got64++; end
  end

  task automatic sweep(input logic [63:0] x, input logic [63:0] y, input logic ci,
                       input logic s, input string nm);
    int g16, g32, g64;
    g16 = got16; g32 = got32; g64 = got64;
    sw_a = x; sw_b = y; sw_cin = ci; sw_sub = s; sw_valid = 1'b1;
    chk({nm, "_rdy"}, {63'd0, r16, r32, r64}, 66'b111);
    step();
    sw_valid = 1'b0;
    repeat (5) step();
    chk({nm, "_n16"}, 66'(got16 - g16), 66'd1);
    chk({nm, "_n32"}, 66'(got32 - g32), 66'd1);
    chk({nm, "_n64"}, 66'(got64 - g64), 66'd1);
    chk({nm, "_w16"}, cap16, model(16, x, y, ci, s));
    chk({nm, "_w32"}, cap32, model(32, x, y, ci, s));
    chk({nm, "_w64"}, cap64, model(64, x, y, ci, s));
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    tbl[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[7]  = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[8]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    tbl[9]  = '{32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
    tbl[10] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    tbl[11] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", {65'd0, out_valid}, 66'd0);
    chk("rst_sum", {34'd0, sum}, 66'd0);
    chk("rst_cout_ovf", {64'd0, cout, ovf}, 66'd0);
    chk("rst_in_ready", {65'd0, in_ready}, 66'd1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back stream, one result per cycle
    mon_en = 1'b1;
    rcvd = 0;
    stream(16, 1000, 0, "b2b");
    chk("b2b_span", 66'(last_t - first_t), 66'd15);

    // Five-cycle stall with a full pipeline
    stream(10, 4, 5, "stall");
    mon_en = 1'b0;

    // Reset with two beats in flight
    out_ready = 1'b1;
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    a = 32'h3333_3333;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {65'd0, out_valid}, 66'd0);
    chk("midrst_sum", {34'd0, sum}, 66'd0);
    chk("midrst_in_ready", {65'd0, in_ready}, 66'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_discard", {65'd0, out_valid}, 66'd0);
    run_vec(tbl[8], "postrst");

    // Carry-boundary sweep over alternate geometries
    sweep('1, 64'd1, 1'b0, 1'b0, "ones_p1");
    sweep(64'd1, '1, 1'b1, 1'b0, "one_pones_c");
    sweep(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0, "a5");
    sweep(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, "a5_c");
    sweep(64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b0, 1'b0, "55");
    sweep(64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, "aa");
    sweep(64'd0, 64'd1, 1'b0, 1'b1, "sub_0m1");
    sweep(64'h8000_8000_8000_8000, 64'h0001_0001_0001_0001, 1'b0, 1'b1, "sub_msb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
